// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Serialises bytes handed over by the CPU's memory-mapped UART path onto
// FPGA_SERIAL_TX as 8N1 frames: one start bit (0), eight data bits LSB
// first, then one stop bit (1). Bit timing comes from a baud counter that
// runs off the system clock.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit. Each frame is then 11 bit
// periods long.
//
// Parameters:
//   CLOCK_FREQ     system clock frequency in Hz
//   BAUD_RATE      line rate in bits/s
//                  (CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE, must be >= 2)
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst            asynchronous, active-high reset
//   data_in        byte to transmit
//   data_in_valid  data_in holds a byte to send
//   data_in_ready  transmitter can accept a byte this cycle (state is IDLE)
//   serial_out     registered line output, idles high
//   busy           a frame is in progress
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_transmitter #(
    parameter int CLOCK_FREQ = 33_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       busy
);

    localparam int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);

    // A bit period shorter than two clocks cannot be timed by this counter.
    if (CYCLES_PER_BIT < 2) begin : g_bad_bit_period
        $error("uart_transmitter: CYCLES_PER_BIT (CLOCK_FREQ / BAUD_RATE) must be at least 2");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       next_bit_idx;
    logic [7:0]       shift;
    logic [7:0]       next_shift;
    logic             next_serial;
    logic             cnt_done;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
    logic             next_parity;
`endif

    assign cnt_done      = (cnt == CNT_LAST);
    assign data_in_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    // Next-state logic. The line level is derived from the *next* state and
    // shift contents so that serial_out can be a flop and still change on
    // the same edge as the state (start bit visible right after accept).
    always_comb begin
        next_state   = state;
        next_cnt     = cnt;
        next_bit_idx = bit_idx;
        next_shift   = shift;
`ifdef UART_TX_PARITY_EN
        next_parity  = parity_bit;
`endif

        case (state)
            IDLE: begin
                if (data_in_valid) begin
                    next_state   = START;
                    next_cnt     = '0;
                    next_bit_idx = '0;
                    next_shift   = data_in;
`ifdef UART_TX_PARITY_EN
                    next_parity  = ^data_in;
`endif
                end
            end

            START: begin
                if (cnt_done) begin
                    next_state = DATA;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end

            // The shift register always presents the current data bit at
            // bit 0; it shifts right at the end of each data bit period.
            DATA: begin
                if (cnt_done) begin
                    next_cnt   = '0;
                    next_shift = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        next_bit_idx = '0;
`ifdef UART_TX_PARITY_EN
                        next_state   = PARITY;
`else
                        next_state   = STOP;
`endif
                    end else begin
                        next_bit_idx = bit_idx + 3'd1;
                    end
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_done) begin
                    next_state = STOP;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
`endif

            STOP: begin
                if (cnt_done) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end

            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase

        next_serial = 1'b1;
        case (next_state)
            START:   next_serial = 1'b0;
            DATA:    next_serial = next_shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  next_serial = next_parity;
`endif
            default: next_serial = 1'b1;
        endcase
    end

    // State register; reset drives the line back to idle-high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            serial_out <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            bit_idx    <= next_bit_idx;
            shift      <= next_shift;
            serial_out <= next_serial;
`ifdef UART_TX_PARITY_EN
            parity_bit <= next_parity;
`endif
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//
// Self-checking bench for uart_transmitter at CLOCK_FREQ=1000, BAUD_RATE=100
// (10 clocks per bit). Expected line levels come from a frame model built
// from the 8N1 rules (plus even parity when UART_TX_PARITY_EN is defined).
// A receiver model samples each data bit mid-period and rebuilds the byte.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_transmitter;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int CPB        = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYCLES = FRAME_BITS * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       serial;
    logic       busy;

    int checks_total  = 0;
    int checks_passed = 0;
    int cycle         = 0;

    uart_transmitter #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data),
        .data_in_valid(valid),
        .data_in_ready(ready),
        .serial_out   (serial),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level expected k clocks after the accept edge of byte b.
    function automatic logic expectedLine(input logic [7:0] b, input int k);
        logic frame [FRAME_BITS];
        frame[0] = 1'b0;
        for (int j = 0; j < 8; j++) frame[j + 1] = b[j];
`ifdef UART_TX_PARITY_EN
        frame[9] = ^b;
`endif
        frame[FRAME_BITS - 1] = 1'b1;
        return frame[k / CPB];
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        valid = v;
        data  = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) begin
            checks_passed++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)",
                   tag, observed, expected, cycle);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".line"},  32'(serial), 32'd1);
        checkOutput({tag, ".ready"}, 32'(ready),  32'd1);
        checkOutput({tag, ".busy"},  32'(busy),   32'd0);
    endtask

    // Offer a byte while idle; returns just after the accepting edge.
    task automatic startFrame(input logic [7:0] b);
        applyStimulus(1'b1, b);
        stepCycle();
    endtask

    // Follows a frame for ncycles clocks from just after its accept edge.
    // offerAt == 0 keeps valid high with nextByte (back-to-back), offerAt > 0
    // raises valid with nextByte at that cycle, otherwise valid drops.
    task automatic runFrame(input string tag, input logic [7:0] b, input int ncycles,
                            input int offerAt, input logic [7:0] nextByte);
        logic [7:0] rx;
        rx = 8'h00;
        for (int i = 0; i < ncycles; i++) begin
            checkOutput($sformatf("%s.line[%0d]", tag, i), 32'(serial), 32'(expectedLine(b, i)));
            checkOutput($sformatf("%s.ready[%0d]", tag, i), 32'(ready), 32'd0);
            checkOutput($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'd1);
            if ((i % CPB) == (CPB / 2) && (i / CPB) >= 1 && (i / CPB) <= 8)
                rx[(i / CPB) - 1] = serial;
            if (i == 0) begin
                if (offerAt == 0) applyStimulus(1'b1, nextByte);
                else              applyStimulus(1'b0, 8'h00);
            end else if (i == offerAt) begin
                applyStimulus(1'b1, nextByte);
            end
            stepCycle();
        end
        if (ncycles == FRAME_CYCLES) begin
            checkOutput({tag, ".rx"}, 32'(rx), 32'(b));
            checkIdle({tag, ".end"});
        end
    endtask

    initial begin
        logic [7:0] rnd;
        int         gap;

        rst = 1'b1;
        applyStimulus(1'b0, 8'h00);

        $display("[TB] reset and idle");
        repeat (3) stepCycle();
        checkIdle("reset.hold");
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            checkIdle($sformatf("idle[%0d]", i));
            stepCycle();
        end

        $display("[TB] single byte 0xA5");
        startFrame(8'hA5);
        runFrame("a5", 8'hA5, FRAME_CYCLES, -1, 8'h00);

        // The second byte is accepted on the edge after ready rises.
        $display("[TB] back-to-back 0x00 then 0xFF");
        startFrame(8'h00);
        runFrame("b2b0", 8'h00, FRAME_CYCLES, 0, 8'hFF);
        stepCycle();
        runFrame("b2b1", 8'hFF, FRAME_CYCLES, -1, 8'h00);

        $display("[TB] valid while busy");
        startFrame(8'h55);
        runFrame("busy55", 8'h55, FRAME_CYCLES, 40, 8'h3C);
        stepCycle();
        runFrame("late3c", 8'h3C, FRAME_CYCLES, -1, 8'h00);

        $display("[TB] reset mid-frame");
        startFrame(8'h81);
        runFrame("rst81", 8'h81, 35, -1, 8'h00);
        rst = 1'b1;
        #1;
        checkIdle("rst.async");
        stepCycle();
        stepCycle();
        checkIdle("rst.held");
        rst = 1'b0;
        startFrame(8'h7E);
        runFrame("after_rst", 8'h7E, FRAME_CYCLES, -1, 8'h00);

        $display("[TB] parity bytes 0x07 and 0x03");
        startFrame(8'h07);
        runFrame("p07", 8'h07, FRAME_CYCLES, 0, 8'h03);
        stepCycle();
        runFrame("p03", 8'h03, FRAME_CYCLES, -1, 8'h00);

        $display("[TB] random bytes");
        for (int n = 0; n < 4; n++) begin
            rnd = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                checkIdle($sformatf("gap%0d[%0d]", n, g));
                stepCycle();
            end
            startFrame(rnd);
            runFrame($sformatf("rnd%0d_%02h", n, rnd), rnd, FRAME_CYCLES, -1, 8'h00);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
